// File: rtl/note_result_hold_if.sv
// Link between the frequency detector (master side) and the result hold stage (slave side).
// Handshake: done is a level with no backpressure; each 0->1 edge of done is one result whose
// note_in/ind_in must be stable on that edge, and update pulses one cycle for every commit.
interface note_result_hold_if #(
  parameter int NOTE_W = 6,
  parameter int IND_W  = 2
);
  logic              done;
  logic [NOTE_W-1:0] note_in;
  logic [IND_W-1:0]  ind_in;
  logic [NOTE_W-1:0] note_out;
  logic [IND_W-1:0]  ind_out;
  logic              valid_out;
  logic              update;
  logic              hold_busy;
  logic              dbg_state;

  modport master (
    output done, note_in, ind_in,
    input  note_out, ind_out, valid_out, update, hold_busy, dbg_state
  );

  modport slave (
    input  done, note_in, ind_in,
    output note_out, ind_out, valid_out, update, hold_busy, dbg_state
  );
endinterface

// File: rtl/note_result_hold.sv
// Stabilises detector results: optional N-in-a-row agreement, a frozen hold window after each
// commit, and a timeout that drops valid_out when the detector goes quiet.
module note_result_hold #(
  parameter int NOTE_W         = 6,
  parameter int IND_W          = 2,
  parameter int HOLD_CYCLES    = 8333334,
  parameter int STABLE_COUNT   = 1,
  parameter int TIMEOUT_CYCLES = 150000000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  note_result_hold_if.slave bus
);
  localparam int SAMPLE_W = NOTE_W + IND_W;
  localparam int HOLD_W   = $clog2(HOLD_CYCLES) + 1;
  localparam int MATCH_W  = $clog2(STABLE_COUNT) + 1;
  localparam int IDLE_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(STABLE_COUNT);
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_done_q;
  logic                w_done_rise;
  logic [SAMPLE_W-1:0] w_sample;
  logic [SAMPLE_W-1:0] r_cand;
  logic [MATCH_W-1:0]  r_match_cnt;
  logic [MATCH_W-1:0]  w_match_next;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic [NOTE_W-1:0]   r_note;
  logic [IND_W-1:0]    r_ind;
  logic                r_valid;
  logic                r_update;
  logic                w_commit;
  logic                w_hold_busy;

  assign w_done_rise = bus.done & ~r_done_q;
  assign w_sample    = {bus.note_in, bus.ind_in};

  // Match count as it will be after this result, so the commit test sees the current sample.
  always_comb begin
    w_match_next = MATCH_W'(1);
    if (w_sample == r_cand) begin
      w_match_next = (r_match_cnt == MATCH_MAX) ? MATCH_MAX : r_match_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_done_q    <= 1'b0;
      r_cand      <= '0;
      r_match_cnt <= '0;
    end else begin
      r_done_q <= bus.done;
      if (w_done_rise) begin
        r_cand      <= w_sample;
        r_match_cnt <= w_match_next;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_commit) w_state_next = S_HOLD;
      S_HOLD:  if (r_hold_cnt == HOLD_LAST) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_commit    = (r_state == S_IDLE) && w_done_rise && (w_match_next >= MATCH_MAX);
    w_hold_busy = (r_state == S_HOLD);
  end

  // Idle counter saturates at its terminal value, so valid_out stays low until the next commit.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_hold_cnt <= '0;
      r_idle_cnt <= '0;
      r_note     <= '0;
      r_ind      <= '0;
      r_valid    <= 1'b0;
      r_update   <= 1'b0;
    end else begin
      r_update <= w_commit;
      if (w_commit) begin
        r_note     <= bus.note_in;
        r_ind      <= bus.ind_in;
        r_valid    <= 1'b1;
        r_hold_cnt <= '0;
        r_idle_cnt <= '0;
      end else begin
        if (r_state == S_HOLD) begin
          r_hold_cnt <= (r_hold_cnt == HOLD_LAST) ? '0 : r_hold_cnt + 1'b1;
        end
        if (r_idle_cnt != IDLE_LAST) begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
        if (TIMEOUT_EN && (r_idle_cnt == IDLE_LAST)) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.note_out  = r_note;
  assign bus.ind_out   = r_ind;
  assign bus.valid_out = r_valid;
  assign bus.update    = r_update;
  assign bus.hold_busy = w_hold_busy;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_note_result_hold.sv
// Three differently parameterised hold stages share one detector stimulus stream and are
// checked every cycle against a timestamp-based model of commit, hold and timeout.
module tb_note_result_hold;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  note_result_hold_if #(.NOTE_W(6), .IND_W(2)) if_a ();
  note_result_hold_if #(.NOTE_W(6), .IND_W(2)) if_b ();
  note_result_hold_if #(.NOTE_W(6), .IND_W(2)) if_c ();

  note_result_hold #(.NOTE_W(6), .IND_W(2), .HOLD_CYCLES(8), .STABLE_COUNT(1),
                     .TIMEOUT_CYCLES(100)) u_a (.CLOCK_50(clk), .reset(reset), .bus(if_a.slave));
  note_result_hold #(.NOTE_W(6), .IND_W(2), .HOLD_CYCLES(2), .STABLE_COUNT(3),
                     .TIMEOUT_CYCLES(0))   u_b (.CLOCK_50(clk), .reset(reset), .bus(if_b.slave));
  note_result_hold #(.NOTE_W(6), .IND_W(2), .HOLD_CYCLES(4), .STABLE_COUNT(1),
                     .TIMEOUT_CYCLES(30))  u_c (.CLOCK_50(clk), .reset(reset), .bus(if_c.slave));

  int p_hold[3] = '{8, 2, 4};
  int p_stab[3] = '{1, 3, 1};
  int p_to[3]   = '{100, 0, 30};

  // Reference model: the last commit is a timestamp; hold and timeout are windows after it.
  int         cyc;
  bit         m_prev_done;
  bit         m_has[3];
  int         m_last[3];
  logic [7:0] m_cand[3];
  int         m_streak[3];
  logic [7:0] m_out[3];
  logic [7:0] exp_q[$];

  int n_vec;
  int n_err;
  int upd_cnt[3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit rst, input bit d, input logic [7:0] s);
    bit rise;
    if (rst) begin
      m_prev_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_has[k] = 1'b0; m_last[k] = -1000000; m_cand[k] = '0; m_streak[k] = 0; m_out[k] = '0;
      end
    end else begin
      rise = d && !m_prev_done;
      m_prev_done = d;
      for (int k = 0; k < 3; k++) begin
        if (rise) begin
          if (s == m_cand[k]) m_streak[k]++;
          else begin m_cand[k] = s; m_streak[k] = 1; end
          if (cyc > m_last[k] + p_hold[k] && m_streak[k] >= p_stab[k]) begin
            m_has[k] = 1'b1; m_last[k] = cyc; m_out[k] = s;
            if (k == 0) exp_q.push_back(s);
          end
        end
      end
    end
  endtask

  function automatic logic [11:0] model_vec(input int k);
    bit v, u, b;
    v = m_has[k] && (p_to[k] == 0 || cyc < m_last[k] + p_to[k]);
    u = m_has[k] && (cyc == m_last[k]);
    b = m_has[k] && (cyc < m_last[k] + p_hold[k]);
    return {m_out[k], v, u, b, b};
  endfunction

  task automatic compare_all();
    logic [11:0] got[3];
    got[0] = {if_a.note_out, if_a.ind_out, if_a.valid_out, if_a.update, if_a.hold_busy, if_a.dbg_state};
    got[1] = {if_b.note_out, if_b.ind_out, if_b.valid_out, if_b.update, if_b.hold_busy, if_b.dbg_state};
    got[2] = {if_c.note_out, if_c.ind_out, if_c.valid_out, if_c.update, if_c.hold_busy, if_c.dbg_state};
    check_eq("a_outputs", 32'(got[0]), 32'(model_vec(0)));
    check_eq("b_outputs", 32'(got[1]), 32'(model_vec(1)));
    check_eq("c_outputs", 32'(got[2]), 32'(model_vec(2)));
    for (int k = 0; k < 3; k++) upd_cnt[k] += int'(got[k][2]);
    if (if_a.update) begin
      check_eq("a_sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_eq("a_sb_value", 32'({if_a.note_out, if_a.ind_out}), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic drive_cycle(input bit rst, input bit d, input logic [5:0] n, input logic [1:0] i);
    @(negedge clk);
    reset = rst;
    if_a.done = d; if_a.note_in = n; if_a.ind_in = i;
    if_b.done = d; if_b.note_in = n; if_b.ind_in = i;
    if_c.done = d; if_c.note_in = n; if_c.ind_in = i;
    @(posedge clk);
    cyc++;
    model_edge(rst, d, {n, i});
    #1;
    compare_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int j = 0; j < n; j++) drive_cycle(1'b0, 1'b0, 6'd0, 2'd0);
  endtask

  initial begin
    int vcnt;
    bit saw5;
    logic [5:0] seq_b[5];
    n_vec = 0; n_err = 0; cyc = 0;
    for (int k = 0; k < 3; k++) upd_cnt[k] = 0;
    reset = 1'b1;
    if_a.done = 1'b0; if_a.note_in = '0; if_a.ind_in = '0;
    if_b.done = 1'b0; if_b.note_in = '0; if_b.ind_in = '0;
    if_c.done = 1'b0; if_c.note_in = '0; if_c.ind_in = '0;

    for (int j = 0; j < 3; j++) drive_cycle(1'b1, 1'(j % 2 == 0), 6'd12, 2'd1);
    check_eq("rst_a_all_zero", 32'({if_a.note_out, if_a.ind_out, if_a.valid_out, if_a.update, if_a.hold_busy}), 32'd0);
    idle_cycles(2);

    drive_cycle(1'b0, 1'b1, 6'd12, 2'b01);
    check_eq("a_first_commit", 32'({if_a.note_out, if_a.ind_out, if_a.update, if_a.hold_busy}), 32'({6'd12, 2'b01, 2'b11}));
    idle_cycles(3);
    drive_cycle(1'b0, 1'b1, 6'd20, 2'b01);
    check_eq("a_hold_freezes", 32'(if_a.note_out), 32'd12);
    idle_cycles(10);
    drive_cycle(1'b0, 1'b1, 6'd20, 2'b01);
    check_eq("a_after_hold", 32'(if_a.note_out), 32'd20);

    idle_cycles(10);
    upd_cnt[2] = 0;
    for (int j = 0; j < 20; j++) drive_cycle(1'b0, 1'b1, 6'd9, 2'd2);
    check_eq("c_done_level_one_update", 32'(upd_cnt[2]), 32'd1);
    idle_cycles(5);

    seq_b = '{6'd5, 6'd5, 6'd7, 6'd7, 6'd7};
    upd_cnt[1] = 0; saw5 = 1'b0;
    for (int r = 0; r < 5; r++) begin
      drive_cycle(1'b0, 1'b1, seq_b[r], 2'd0);
      if (if_b.note_out == 6'd5) saw5 = 1'b1;
      if (r == 3) check_eq("b_no_early_commit", 32'(upd_cnt[1]), 32'd0);
      for (int j = 0; j < 3; j++) begin
        drive_cycle(1'b0, 1'b0, 6'd0, 2'd0);
        if (if_b.note_out == 6'd5) saw5 = 1'b1;
      end
    end
    check_eq("b_one_commit", 32'(upd_cnt[1]), 32'd1);
    check_eq("b_note_7", 32'({if_b.note_out, if_b.ind_out}), 32'({6'd7, 2'd0}));
    check_eq("b_never_5", 32'(saw5), 32'd0);

    idle_cycles(20);
    drive_cycle(1'b0, 1'b1, 6'd33, 2'd2);
    vcnt = int'(if_a.valid_out);
    for (int j = 0; j < 110; j++) begin
      drive_cycle(1'b0, 1'b0, 6'd0, 2'd0);
      vcnt += int'(if_a.valid_out);
    end
    check_eq("a_timeout_len", 32'(vcnt), 32'd100);
    check_eq("a_timeout_keeps_note", 32'({if_a.note_out, if_a.ind_out, if_a.valid_out}), 32'({6'd33, 2'd2, 1'b0}));
    drive_cycle(1'b0, 1'b1, 6'd34, 2'd1);
    check_eq("a_valid_restored", 32'(if_a.valid_out), 32'd1);

    idle_cycles(10);
    drive_cycle(1'b0, 1'b1, 6'd40, 2'd3);
    idle_cycles(2);
    drive_cycle(1'b1, 1'b0, 6'd0, 2'd0);
    check_eq("a_reset_mid_hold", 32'({if_a.note_out, if_a.ind_out, if_a.valid_out, if_a.hold_busy}), 32'd0);
    drive_cycle(1'b0, 1'b1, 6'd41, 2'd1);
    check_eq("a_commit_after_reset", 32'({if_a.note_out, if_a.ind_out, if_a.update}), 32'({6'd41, 2'd1, 1'b1}));

    for (int j = 0; j < 3000; j++) begin
      drive_cycle(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 2) == 0),
                  6'($urandom_range(0, 3)), 2'($urandom_range(0, 1)));
    end
    idle_cycles(2);
    check_eq("a_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
